vend_countdown_timer: RTL and testbench

- Consumer end of the 1 Hz clock-enable interface: counts whole seconds from a single-cycle tick enable, not from a derived clock.
- Provides the vending machine's selection/dispense timeouts.
- Loads a seconds value, decrements once per tick, presents remaining time as binary and BCD for the 7-segment display, and flags expiry.
- Runs entirely on the system clock clk; tick_en comes from the 1 Hz enable generator.

---
 rtl/vend_countdown_timer.sv | 161 ++++++++++++++++
 tb/tb_vend_countdown_timer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vend_countdown_timer.sv
// Seconds countdown for the vending machine's selection/dispense timeouts, driven by a 1 Hz tick enable.
// Optional tick watchdog is compiled in with `define VEND_TICK_WATCHDOG_EN.
module vend_countdown_timer #(
  parameter int SEC_W       = 7,
  parameter int DEFAULT_SEC = 30,
  parameter int WD_CYCLES   = 110000000
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             tick_en,
  input  logic             start,
  input  logic [SEC_W-1:0] load_val,
  input  logic             pause,
  input  logic             cancel,
  output logic             busy,
  output logic [SEC_W-1:0] remaining,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             done,
  output logic             expired,
  output logic             tick_missing,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HOLD    = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [SEC_W-1:0] MAX_SEC = SEC_W'(99);
  localparam logic [SEC_W-1:0] DEF_SEC = SEC_W'(DEFAULT_SEC);
  localparam logic [SEC_W-1:0] ONE_SEC = SEC_W'(1);
  localparam logic [SEC_W-1:0] TEN     = SEC_W'(10);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEC_W-1:0] r_remaining;
  logic [SEC_W-1:0] w_rem_nxt;
  logic             w_done_nxt;
  logic [SEC_W-1:0] w_load;
  logic [SEC_W-1:0] w_tens;
  logic [SEC_W-1:0] w_ones;

  // Zero means "use the default timeout"; anything past two digits saturates.
  always_comb begin
    w_load = load_val;
    if (load_val == '0) begin
      w_load = DEF_SEC;
    end else if (load_val > MAX_SEC) begin
      w_load = MAX_SEC;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_remaining;
    w_done_nxt  = 1'b0;
    if (cancel) begin
      w_state_nxt = IDLE;
      w_rem_nxt   = '0;
    end else if (start) begin
      w_state_nxt = RUN;
      w_rem_nxt   = w_load;
    end else begin
      case (r_state)
        RUN: begin
          if (pause) begin
            w_state_nxt = HOLD;
          end else if (tick_en) begin
            if (r_remaining > ONE_SEC) begin
              w_rem_nxt = r_remaining - ONE_SEC;
            end else begin
              w_rem_nxt   = '0;
              w_state_nxt = EXPIRED;
              w_done_nxt  = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!pause) begin
            w_state_nxt = RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Display digits follow the next count so they change on the same edge.
  assign w_tens = w_rem_nxt / TEN;
  assign w_ones = w_rem_nxt % TEN;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_remaining <= '0;
      bcd_tens    <= '0;
      bcd_ones    <= '0;
      done        <= 1'b0;
      expired     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_remaining <= w_rem_nxt;
      bcd_tens    <= w_tens[3:0];
      bcd_ones    <= w_ones[3:0];
      done        <= w_done_nxt;
      expired     <= (w_state_nxt == EXPIRED);
      busy        <= (w_state_nxt == RUN) || (w_state_nxt == HOLD);
    end
  end

  assign remaining = r_remaining;
  assign state_dbg = r_state;

`ifdef VEND_TICK_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WD_CYCLES);

  logic [WD_W-1:0] r_wd_cnt;
  logic [WD_W-1:0] w_wd_inc;
  logic            w_wd_run;
  logic            r_tick_missing;

  assign w_wd_inc = r_wd_cnt + 1'b1;
  // Counting only while RUN persists across this edge with no tick and no reload.
  assign w_wd_run = (r_state == RUN) && (w_state_nxt == RUN) && !tick_en && !start;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_wd_cnt       <= '0;
      r_tick_missing <= 1'b0;
    end else begin
      if (cancel || start) begin
        r_tick_missing <= 1'b0;
      end else if (w_wd_run && (w_wd_inc == WD_LIMIT)) begin
        r_tick_missing <= 1'b1;
      end
      if (!w_wd_run) begin
        r_wd_cnt <= '0;
      end else if (r_wd_cnt != WD_LIMIT) begin
        r_wd_cnt <= w_wd_inc;
      end
    end
  end

  assign tick_missing = r_tick_missing;
`else
  assign tick_missing = 1'b0;
`endif

endmodule

// File: tb/tb_vend_countdown_timer.sv
// Directed plus randomized bench for vend_countdown_timer against a per-edge behavioural model.
module tb_vend_countdown_timer;

  localparam int SEC_W = 7;

  logic             clk = 1'b0;
  logic             clr;
  logic             tick_en;
  logic             start;
  logic [SEC_W-1:0] load_val;
  logic             pause;
  logic             cancel;
  logic             busy;
  logic [SEC_W-1:0] remaining;
  logic [3:0]       bcd_tens;
  logic [3:0]       bcd_ones;
  logic             done;
  logic             expired;
  logic             tick_missing;
  logic [1:0]       state_dbg;

  vend_countdown_timer #(
    .SEC_W(SEC_W),
    .DEFAULT_SEC(30),
    .WD_CYCLES(110000000)
  ) dut (
    .clk(clk),
    .clr(clr),
    .tick_en(tick_en),
    .start(start),
    .load_val(load_val),
    .pause(pause),
    .cancel(cancel),
    .busy(busy),
    .remaining(remaining),
    .bcd_tens(bcd_tens),
    .bcd_ones(bcd_ones),
    .done(done),
    .expired(expired),
    .tick_missing(tick_missing),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: seconds left plus three flags describing what the timer is doing.
  int m_rem      = 0;
  bit m_counting = 0;
  bit m_paused   = 0;
  bit m_exp      = 0;
  bit m_done     = 0;
  int n_done_obs = 0;
  int n_done_exp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_counting = 0; m_paused = 0; m_exp = 0; m_done = 0;
  endtask

  task automatic model_step(input bit c, input bit s, input bit p, input bit t, input int lv);
    int load;
    load = (lv == 0) ? 30 : ((lv > 99) ? 99 : lv);
    m_done = 0;
    if (c) begin
      m_rem = 0; m_counting = 0; m_paused = 0; m_exp = 0;
    end else if (s) begin
      m_rem = load; m_counting = 1; m_paused = 0; m_exp = 0;
    end else if (m_counting) begin
      if (p) begin
        m_counting = 0; m_paused = 1;
      end else if (t) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_counting = 0; m_exp = 1; m_done = 1;
        end
      end
    end else if (m_paused && !p) begin
      m_paused = 0; m_counting = 1;
    end
    if (m_done) n_done_exp++;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_rem"}, 32'(remaining), m_rem);
    chk({tag, "_tens"}, 32'(bcd_tens), m_rem / 10);
    chk({tag, "_ones"}, 32'(bcd_ones), m_rem % 10);
    chk({tag, "_done"}, 32'(done), 32'(m_done));
    chk({tag, "_expired"}, 32'(expired), 32'(m_exp));
    chk({tag, "_busy"}, 32'(busy), 32'(m_counting | m_paused));
    chk({tag, "_wd"}, 32'(tick_missing), 0);
  endtask

  task automatic step(input string tag, input bit c, input bit s, input bit p, input bit t,
                      input int lv);
    @(negedge clk);
    cancel = c; start = s; pause = p; tick_en = t; load_val = SEC_W'(lv);
    @(posedge clk);
    model_step(c, s, p, t, lv);
    #1;
    if (done === 1'b1) n_done_obs++;
    check_all(tag);
  endtask

  initial begin
    bit r_p;
    clr = 1'b1; tick_en = 0; start = 0; pause = 0; cancel = 0; load_val = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    clr = 1'b0;

    // Asynchronous clear while counting at 17
    step("load17", 0, 1, 0, 0, 17);
    step("run17", 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 clr = 1'b1;
    #1 model_reset();
    check_all("async_clr");
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 3; i++) step("post_clr_tick", 0, 0, 0, 1, 0);

    // 3 second countdown, ticks 10 clocks apart
    step("load3", 0, 1, 0, 0, 3);
    for (int k = 0; k < 5; k++) begin
      step("cd_tick", 0, 0, 0, 1, 0);
      for (int i = 0; i < 9; i++) step("cd_gap", 0, 0, 0, 0, 0);
    end
    chk("cd_expired_level", 32'(expired), 1);
    chk("cd_done_count", n_done_obs, 1);

    // Default load and saturation
    step("load0", 0, 1, 0, 0, 0);
    chk("default_tens", 32'(bcd_tens), 3);
    chk("default_ones", 32'(bcd_ones), 0);
    step("load120", 0, 1, 0, 0, 120);
    chk("sat_rem", 32'(remaining), 99);

    // Pause across three ticks, then resume
    step("load12", 0, 1, 0, 0, 12);
    for (int i = 0; i < 3; i++) begin
      step("pause_tick", 0, 0, 1, 1, 0);
      step("pause_gap", 0, 0, 1, 0, 0);
    end
    chk("pause_hold", 32'(remaining), 12);
    step("resume", 0, 0, 0, 0, 0);
    step("resume_tick", 0, 0, 0, 1, 0);
    chk("resume_rem", 32'(remaining), 11);

    // Coincident events
    step("start_tick", 0, 1, 0, 1, 5);
    chk("start_tick_rem", 32'(remaining), 5);
    step("cancel_start", 1, 1, 0, 1, 9);
    chk("cancel_start_rem", 32'(remaining), 0);
    step("idle_tick", 0, 0, 1, 1, 0);

    // Start held high keeps reloading
    for (int i = 0; i < 4; i++) step("start_held", 0, 1, 0, 1, 2);
    step("retrig_tick", 0, 0, 0, 1, 0);
    step("retrig_tick2", 0, 0, 0, 1, 0);

    // Randomized traffic
    r_p = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) r_p = ~r_p;
      step("rand", ($urandom_range(0, 59) == 0), ($urandom_range(0, 24) == 0), r_p,
           ($urandom_range(0, 2) == 0), int'($urandom_range(0, 127)));
    end
    chk("done_total", n_done_obs, n_done_exp);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
